// File: rtl/multibyte_add_seq.sv
// multibyte_add_seq
//   Performs an NBYTES*8-bit add or subtract by feeding one byte per cycle,
//   LSB first, through an external 8-bit ripple-carry adder. The carry
//   between bytes is kept in a register. The wide result is held after
//   completion, and a one-cycle done pulse marks it valid.
//
//   state | meaning
//   IDLE  | waiting for start; adder inputs held at 0
//   RUN   | one byte per cycle through the external adder
//   DONE  | result valid, done pulse, back to IDLE next cycle
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   start, sub        request; 0 = add, 1 = subtract (op_a - op_b)
//   cin_in            carry-in (add) / borrow-in (sub)
//   op_a, op_b        W-bit operands, sampled with an accepted start
//   add_a/add_b/cin   byte operands and carry driven to the external adder
//   add_sum/add_cout  external adder response (combinational)
//   busy, done        status: busy when not IDLE, done for one cycle
//   result            W-bit sum/difference, held until next accepted start
//   cout_out          final carry (sub: 1 = no borrow)
//   ovf               signed two's-complement overflow
module multibyte_add_seq #(
    parameter int NBYTES = 4,
    parameter int W      = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic         cin_in,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic [7:0]   add_a,
    output logic [7:0]   add_b,
    output logic         add_cin,
    input  logic [7:0]   add_sum,
    input  logic         add_cout,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout_out,
    output logic         ovf
);

    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    result_q, result_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    // Bit offset of the current byte within the wide registers.
    logic [IDXW+2:0] bit_off;
    assign bit_off = {idx_q, 3'b000};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        add_a    = 8'h00;
        add_b    = 8'h00;
        add_cin  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtract as a + ~b + ~borrow_in.
                    a_d      = op_a;
                    b_d      = sub ? ~op_b : op_b;
                    carry_d  = sub ^ cin_in;
                    idx_d    = '0;
                    result_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                add_a   = a_q[bit_off +: 8];
                add_b   = b_q[bit_off +: 8];
                add_cin = carry_q;
                result_d[bit_off +: 8] = add_sum;
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    cout_d  = add_cout;
                    // Operands (with b already inverted for sub) agree in sign
                    // but the top sum bit differs.
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[7] != a_q[W-1]);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign result   = result_q;
    assign cout_out = cout_q;
    assign ovf      = ovf_q;

endmodule

// File: doc/multibyte_add_seq.md
Name: multibyte_add_seq

Overview:
- Sequencer that performs wide add/subtract operations (NBYTES×8 bits) by time-multiplexing one external 8-bit ripple-carry adder, one byte per cycle, LSB first.
- Drives the adder's a, b and cin inputs, consumes its sum and cout, and chains the carry between bytes in a register.
- Sits between the datapath's operand source and the 8-bit adder; hands back a held wide result with a one-cycle completion pulse.

Parameters:
- NBYTES, 4, operand width in bytes (NBYTES ≥ 1); W = 8*NBYTES.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- sub  in  1  0 = add, 1 = subtract (op_a − op_b); sampled with start.
- cin_in  in  1  carry-in (add) / active-high borrow-in (sub); sampled with start.
- op_a  in  W  operand A; sampled with start.
- op_b  in  W  operand B; sampled with start.
- add_a  out  8  byte of A to the adder.
- add_b  out  8  byte of B (inverted if sub) to the adder.
- add_cin  out  1  chained carry to the adder.
- add_sum  in  8  adder sum (combinational from add_a/add_b/add_cin).
- add_cout  in  1  adder carry-out.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse: result valid.
- result  out  W  wide sum/difference, held until next accepted start.
- cout_out  out  1  final carry; for sub, 1 = no borrow.
- ovf  out  1  signed two's-complement overflow of the wide operation.

Behaviour:
- Reset (rst_n low at a rising edge): state IDLE; result, cout_out, ovf, done, busy, byte index and carry register all 0. add_a/add_b/add_cin = 0. Reset during RUN aborts the operation with no done pulse.
- FSM states are IDLE, RUN and DONE.
- IDLE → RUN on an edge with start = 1:
  - Latch a_reg = op_a.
  - Latch b_reg = sub ? ~op_b : op_b.
  - Set carry_reg = sub ? ~cin_in : cin_in.
  - Set idx = 0.
  - Clear result.
- RUN, each cycle:
  - add_a = a_reg[8*idx +: 8], add_b = b_reg[8*idx +: 8], add_cin = carry_reg.
  - At the edge: result[8*idx +: 8] ← add_sum; carry_reg ← add_cout.
  - If idx = NBYTES−1: go to DONE, cout_out ← add_cout, ovf ← (a_reg[W−1] == b_reg[W−1]) && (add_sum[7] != a_reg[W−1]). Otherwise idx ← idx+1.
- DONE: done = 1 and busy = 1 for exactly one cycle, then → IDLE.
- Latency: the start edge is E0. Bytes are captured at edges E1..E_NBYTES. done is high in the cycle after E_NBYTES. Throughput is one operation per NBYTES+2 cycles.
- Outside RUN, add_a/add_b/add_cin are driven to 0.
- start while busy (RUN or DONE) is ignored; no queuing.
- Operands may change after the start edge without affecting the operation.
- result/cout_out/ovf remain stable from DONE until the next accepted start.
- result is cleared at the accepted start edge.
- The idx counter is at least 1 bit wide; with NBYTES = 1, RUN lasts one cycle.
- No arithmetic occurs inside the block beyond the inversion and the overflow compare; all addition uses the external adder.

Test Plan (NBYTES=4; bench models the adder as {cout,sum} = a+b+cin):
- Add 0x000000FF + 0x00000001, cin_in=0 → result 0x00000100, cout_out 0, ovf 0. Start sampled at E0; done high only in the cycle after E4; busy high E0–E5.
- Add 0xFFFFFFFF + 0x00000000, cin_in=1 → result 0x00000000, cout_out 1, ovf 0. add_cin = 1 observed on all four byte cycles.
- Add 0x7FFFFFFF + 0x00000001 → result 0x80000000, cout_out 0, ovf 1.
- Sub 0x00000005 − 0x00000007, cin_in=0 → result 0xFFFFFFFE, cout_out 0 (borrow), ovf 0. Sub 0x80000000 − 0x00000001 → 0x7FFFFFFF, cout_out 1, ovf 1.
- Start add 0x11111111 + 0x22222222; pulse start with different operands at E2 → ignored, result 0x33333333. A second start in the DONE cycle is also ignored.
- Start any operation, drive rst_n low at E2 → at E3 busy 0, result 0, no done pulse thereafter. A new start after reset completes normally.
